// File: rtl/alu_writeback_if.sv
// Bundle of the ALU-side accept port, the register-file write port and architectural status.
// The slave modport is the retire stage; master is whoever drives the ALU results and the register file.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 16
`endif

interface alu_writeback_if #(
  parameter int n = `DEFAULT_WIDTH,
  parameter int r = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [n-1:0] in_data;
  logic [r-1:0] in_dest;
  logic         in_wen;
  logic [3:0]   in_fmask;
  logic [3:0]   in_flags;
  logic         rf_wen;
  logic [r-1:0] rf_addr;
  logic [n-1:0] rf_data;
  logic         rf_ready;
  logic [3:0]   flags;
  logic         flag_c;
  logic         busy;

  modport master (
    output in_valid, in_data, in_dest, in_wen, in_fmask, in_flags, rf_ready,
    input  in_ready, rf_wen, rf_addr, rf_data, flags, flag_c, busy
  );

  modport slave (
    input  in_valid, in_data, in_dest, in_wen, in_fmask, in_flags, rf_ready,
    output in_ready, rf_wen, rf_addr, rf_data, flags, flag_c, busy
  );
endinterface

// File: rtl/alu_writeback.sv
// ALU retire stage: 2-entry skid FIFO draining to the register-file write port; commits masked flags on retire.
// Entry visible on rf_* one cycle after accept; in_ready drops only when full, never looks at rf_ready.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 16
`endif

module alu_writeback #(
  parameter int n = `DEFAULT_WIDTH,
  parameter int r = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_writeback_if.slave bus
);

  typedef struct packed {
    logic [n-1:0] data;
    logic [r-1:0] dest;
    logic         wen;
    logic [3:0]   fmask;
    logic [3:0]   flags;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  entry_t     mem [2];
  entry_t     head_e;
  logic       head;
  logic       tail;
  state_t     state;
  logic [3:0] flags_q;
  logic       accept;
  logic       retire;

  assign head_e = mem[head];
  assign accept = bus.in_valid && bus.in_ready;
  // wen=0 entries drain without waiting on the register file
  assign retire = (state != EMPTY) && (!head_e.wen || bus.rf_ready);

  assign bus.in_ready = (state != FULL);
  assign bus.busy     = (state != EMPTY);
  assign bus.rf_wen   = (state != EMPTY) && head_e.wen;
  assign bus.rf_addr  = head_e.dest;
  assign bus.rf_data  = head_e.data;
  assign bus.flags    = flags_q;
  assign bus.flag_c   = flags_q[3];

  // Payload storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[tail] <= '{data:  bus.in_data,
                     dest:  bus.in_dest,
                     wen:   bus.in_wen,
                     fmask: bus.in_fmask,
                     flags: bus.in_flags};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      head    <= 1'b0;
      tail    <= 1'b0;
      flags_q <= 4'b0000;
    end else begin
      if (accept) begin
        tail <= ~tail;
      end
      if (retire) begin
        head    <= ~head;
        flags_q <= (flags_q & ~head_e.fmask) | (head_e.flags & head_e.fmask);
      end
      case (state)
        EMPTY: if (accept) state <= ONE;
        ONE: begin
          if (accept && !retire) begin
            state <= FULL;
          end else if (!accept && retire) begin
            state <= EMPTY;
          end
        end
        FULL:    if (retire) state <= ONE;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: reset, single write, backpressure, masked flags, no-write drain, streaming.
module tb_alu_writeback;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  alu_writeback_if #(.n(16), .r(4)) bus ();

  alu_writeback #(.n(16), .r(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] dst,
                       input logic w, input logic [3:0] fm, input logic [3:0] fl);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_dest  = dst;
    bus.in_wen   = w;
    bus.in_fmask = fm;
    bus.in_flags = fl;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.rf_ready = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    #3;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_busy",     32'(bus.busy),     32'd0);
    chk("reset_rf_wen",   32'(bus.rf_wen),   32'd0);
    chk("reset_flags",    32'(bus.flags),    32'h0);
    chk("reset_flag_c",   32'(bus.flag_c),   32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // single write
    drive(1'b1, 16'h00A5, 4'd3, 1'b1, 4'b1111, 4'b1001);
    bus.rf_ready = 1'b1;
    tick();
    drive(1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    chk("single_rf_wen",  32'(bus.rf_wen),  32'd1);
    chk("single_rf_addr", 32'(bus.rf_addr), 32'd3);
    chk("single_rf_data", 32'(bus.rf_data), 32'h00A5);
    chk("single_busy",    32'(bus.busy),    32'd1);
    chk("single_flags_pre", 32'(bus.flags), 32'h0);
    tick();
    chk("single_flags",  32'(bus.flags),  32'b1001);
    chk("single_flag_c", 32'(bus.flag_c), 32'd1);
    chk("single_busy_after", 32'(bus.busy), 32'd0);
    chk("single_rf_wen_after", 32'(bus.rf_wen), 32'd0);

    // backpressure: three pushes against a stalled register file
    bus.rf_ready = 1'b0;
    drive(1'b1, 16'h0001, 4'd1, 1'b1, 4'b0000, 4'b0000);
    chk("bp_ready0", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b1, 16'h0002, 4'd2, 1'b1, 4'b0000, 4'b0000);
    chk("bp_ready1", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b1, 16'h0003, 4'd3, 1'b1, 4'b0000, 4'b0000);
    chk("bp_full_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_head_data",  32'(bus.rf_data),  32'h0001);
    chk("bp_head_wen",   32'(bus.rf_wen),   32'd1);
    tick();
    chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_hold_data",  32'(bus.rf_data),  32'h0001);
    chk("bp_hold_addr",  32'(bus.rf_addr),  32'd1);
    bus.rf_ready = 1'b1;
    tick();
    chk("bp_drain2_data",  32'(bus.rf_data),  32'h0002);
    chk("bp_drain2_ready", 32'(bus.in_ready), 32'd1);
    tick();
    drive(1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    chk("bp_drain3_data", 32'(bus.rf_data), 32'h0003);
    chk("bp_drain3_wen",  32'(bus.rf_wen),  32'd1);
    tick();
    chk("bp_empty_busy", 32'(bus.busy),  32'd0);
    chk("bp_flags_hold", 32'(bus.flags), 32'b1001);

    // masked flags: first set all flags via a no-write entry
    bus.rf_ready = 1'b0;
    drive(1'b1, 16'h0000, 4'd0, 1'b0, 4'b1111, 4'b1111);
    tick();
    drive(1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    chk("mask_nowrite_wen", 32'(bus.rf_wen), 32'd0);
    chk("mask_nowrite_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("mask_set_all", 32'(bus.flags), 32'b1111);
    bus.rf_ready = 1'b1;
    drive(1'b1, 16'h0055, 4'd5, 1'b1, 4'b0101, 4'b0000);
    tick();
    drive(1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    tick();
    chk("mask_flags",  32'(bus.flags),  32'b1010);
    chk("mask_flag_c", 32'(bus.flag_c), 32'd1);

    // no-write entries with the register file stalled
    bus.rf_ready = 1'b0;
    drive(1'b1, 16'h0011, 4'd6, 1'b0, 4'b1000, 4'b0000);
    tick();
    drive(1'b1, 16'h0022, 4'd7, 1'b0, 4'b1000, 4'b1000);
    chk("nw_rf_wen0", 32'(bus.rf_wen), 32'd0);
    tick();
    drive(1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    chk("nw_flags_mid", 32'(bus.flags),  32'b0010);
    chk("nw_rf_wen1",   32'(bus.rf_wen), 32'd0);
    chk("nw_busy_mid",  32'(bus.busy),   32'd1);
    tick();
    chk("nw_flag_c",    32'(bus.flag_c), 32'd1);
    chk("nw_flags_end", 32'(bus.flags),  32'b1010);
    chk("nw_busy_end",  32'(bus.busy),   32'd0);

    // streaming 8 entries back to back
    bus.rf_ready = 1'b1;
    drive(1'b1, 16'h0100, 4'd0, 1'b1, 4'b0000, 4'b0000);
    tick();
    for (int i = 1; i < 8; i++) begin
      drive(1'b1, 16'(16'h0100 + i), 4'(i), 1'b1, 4'b0000, 4'b0000);
      chk("stream_wen",   32'(bus.rf_wen),   32'd1);
      chk("stream_data",  32'(bus.rf_data),  32'(16'h0100 + i - 1));
      chk("stream_addr",  32'(bus.rf_addr),  32'(i - 1));
      chk("stream_ready", 32'(bus.in_ready), 32'd1);
      chk("stream_busy",  32'(bus.busy),     32'd1);
      tick();
    end
    drive(1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    chk("stream_last_data", 32'(bus.rf_data), 32'h0107);
    tick();
    chk("stream_done_busy", 32'(bus.busy), 32'd0);

    // async reset in the middle of a stalled write
    bus.rf_ready = 1'b0;
    drive(1'b1, 16'hBEEF, 4'd9, 1'b1, 4'b1111, 4'b0101);
    tick();
    drive(1'b0, 16'h0, 4'h0, 1'b0, 4'h0, 4'h0);
    chk("arst_pre_wen",   32'(bus.rf_wen), 32'd1);
    chk("arst_pre_flags", 32'(bus.flags),  32'b1010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_flags",    32'(bus.flags),    32'h0);
    chk("arst_flag_c",   32'(bus.flag_c),   32'd0);
    chk("arst_rf_wen",   32'(bus.rf_wen),   32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_busy",     32'(bus.busy),     32'd0);
    #1;
    rst_n = 1'b1;
    bus.rf_ready = 1'b1;
    tick();
    chk("arst_post_busy",  32'(bus.busy),  32'd0);
    chk("arst_post_flags", 32'(bus.flags), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Retire stage directly downstream of the ALU. It captures each ALU result with its condition flags, destination register index and update controls into a two-entry skid FIFO. It then drains entries in order to the register-file write port under a ready/valid handshake. On retirement it commits the masked flags into the architectural flag register, whose carry bit feeds back as the ALU's carry-in for the next operation.

## Interface

- n, `DEFAULT_WIDTH, data width (matches ALU).
- r, 4, register index width (2^r architectural registers).

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream has a result this cycle.
- in_ready  output  1  block can accept an entry this cycle.
- in_data  input  n  ALU out.
- in_dest  input  r  destination register index.
- in_wen  input  1  result is to be written to the register file.
- in_fmask  input  4  flag update mask {C,V,S,Z}; 1 = update that flag.
- in_flags  input  4  ALU {carry, overflow, sign, zero}.
- rf_wen  output  1  register-file write request (valid).
- rf_addr  output  r  write index.
- rf_data  output  n  write data.
- rf_ready  input  1  register file accepts the write this cycle.
- flags  output  4  architectural {C,V,S,Z}.
- flag_c  output  1  equals flags[3]; carry-in source for the ALU.
- busy  output  1  FIFO holds at least one entry.

## Operation

- Storage: 2 entries, each {data, dest, wen, fmask, flags}, plus a head pointer, a tail pointer (1 bit each) and a count (0..2).
- Accept: when in_valid && in_ready is sampled at an edge, write the entry at tail, advance tail, and increment count.
- in_ready = (count != 2). It is combinational from registered count only and has no dependency on rf_ready.
- Head view: rf_addr/rf_data always show the head entry. rf_wen = (count != 0) && head.wen.
- Retire condition: count != 0 && (!head.wen || rf_ready).
  - Entries with wen=0 retire one per cycle without handshake.
  - rf_ready is ignored when rf_wen=0.
- On retire:
  - advance head and decrement count.
  - for each bit i with head.fmask[i]=1, flags[i] <= head.flags[i]; bits with fmask[i]=0 hold.
- Simultaneous accept and retire: count is unchanged. Both pointers advance. This is legal at count=1, and at count=0 only accept occurs.
- Full (count=2): in_ready=0. Upstream must hold in_* stable until accepted.
- Empty (count=0): rf_wen=0. rf_addr/rf_data are don't-care (implementation holds the last values).
- Pointer wrap: the 1-bit pointers wrap naturally 1->0.
- Handshake rule: once rf_wen=1, rf_addr/rf_data/rf_wen stay stable until rf_ready is sampled high.
- States (by count): EMPTY(0), ONE(1), FULL(2).
  - EMPTY->ONE on accept.
  - ONE->EMPTY on retire without accept.
  - ONE->FULL on accept without retire.
  - FULL->ONE on retire (no accept possible).
  - All other combinations: self-loop.

## Timing

- Reset (rst_n low, asynchronous): count=0, pointers=0, flags=4'b0000, flag_c=0, rf_wen=0, busy=0, in_ready=1. Entry storage is not reset.
- Reset mid-operation discards all pending entries immediately. Flags return to 0 even if an entry was mid-handshake.
- Latency: an entry accepted at edge N appears on rf_* in cycle N+1. Its earliest retire edge is N+1. The resulting flags are visible from cycle N+2.
- Throughput: 1 entry/cycle sustained while rf_ready=1 (or wen=0).
- Flag hazard: flag_c reflects only retired entries. Upstream must not issue a carry-consuming op while busy=1 if the preceding op updates C.

## Test plan

- Reset with rst_n low mid-cycle -> flags=0, rf_wen=0, in_ready=1, busy=0 asynchronously, without waiting for a clock edge.
- Single write: in_data=0x00A5, dest=3, wen=1, fmask=4'b1111, in_flags=4'b1001, rf_ready=1 -> next cycle rf_wen=1, rf_addr=3, rf_data=0x00A5. After that edge, flags=4'b1001 and busy=0.
- Backpressure: rf_ready=0, push three entries (0x1, 0x2, 0x3) -> first two accepted, in_ready=0 with count=2, and the third is held. Raise rf_ready -> writes retire in order 0x1, 0x2, 0x3, one per cycle.
- Masked flags: flags=4'b1111, retire an entry with fmask=4'b0101 and in_flags=4'b0000 -> flags=4'b1010 and flag_c=1.
- No-write entries with rf_ready tied 0: push entries with wen=0, fmask=4'b1000, in_flags C=0, then C=1 -> both retire in consecutive cycles, rf_wen never asserts, final flag_c=1.
- Simultaneous accept and retire at count=1 with continuous streaming (in_valid=1, rf_ready=1, 8 entries) -> count stays 1, in_ready stays 1, and 8 writes come out in order with no bubbles after the first.
